// File: rtl/cdc_tx.sv
// Source half of a toggle-handshake CDC: launches one word per xfer_req toggle and
// waits for the synchronized xfer_ack toggle to match. Define CDC_TX_SKID_EN for a one-entry skid buffer.
module cdc_tx #(
    parameter int DATAWIDTH = 8,
    parameter int NSTAGES   = 2
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] xfer_data,
    output logic                 xfer_req,
    input  logic                 xfer_ack,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NSTAGES-1:0]   ack_sync;
    logic                 ack_s;
    logic                 accept;
    logic                 complete;
    logic                 launch;
    logic [DATAWIDTH-1:0] launch_data;

    assign ack_s    = ack_sync[NSTAGES-1];
    assign accept   = in_valid & in_ready;
    assign complete = (state == WAIT) && (ack_s == xfer_req);

`ifdef CDC_TX_SKID_EN
    logic                 skid_full;
    logic [DATAWIDTH-1:0] skid_data;
    logic                 skid_wr;
    logic                 skid_rd;

    assign in_ready = !skid_full;
`else
    assign in_ready = (state == IDLE);
`endif

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        launch_data = in_data;
`ifdef CDC_TX_SKID_EN
        skid_wr     = 1'b0;
        skid_rd     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    launch    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (complete) begin
`ifdef CDC_TX_SKID_EN
                    // A queued word always goes first; a direct accept only when the skid is empty.
                    if (skid_full) begin
                        launch      = 1'b1;
                        launch_data = skid_data;
                        skid_rd     = 1'b1;
                    end else if (accept) begin
                        launch = 1'b1;
                    end
`endif
                    if (!launch) begin
                        state_nxt = IDLE;
                    end
                end
`ifdef CDC_TX_SKID_EN
                else if (accept) begin
                    skid_wr = 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= IDLE;
            ack_sync  <= '0;
            xfer_data <= '0;
            xfer_req  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ack_sync <= {ack_sync[NSTAGES-2:0], xfer_ack};
            done     <= complete;
            busy     <= (state_nxt == WAIT);
            if (launch) begin
                xfer_data <= launch_data;
                xfer_req  <= ~xfer_req;
            end
        end
    end

`ifdef CDC_TX_SKID_EN
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (skid_wr) begin
            skid_full <= 1'b1;
            skid_data <= in_data;
        end else if (skid_rd) begin
            skid_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cdc_tx.sv
// Directed bench for cdc_tx with a loopback destination that acks 3 cycles after seeing req.
module tb_cdc_tx;

    logic       clk;
    logic       reset_l;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] xfer_data;
    logic       xfer_req;
    logic       xfer_ack;
    logic       done;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    cdc_tx #(.DATAWIDTH(8), .NSTAGES(2)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xfer_data (xfer_data),
        .xfer_req  (xfer_req),
        .xfer_ack  (xfer_ack),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Destination model and monitors, all acting on the falling edge.
    logic       ack_en = 1'b1;
    logic       dst_req = 1'b0;
    int         ack_cnt = 0;
    logic [7:0] rx_q[$];
    int         done_cnt = 0;
    int         tog_cnt = 0;
    int         stable_err = 0;
    logic       prev_req = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_l) begin
                dst_req  = 1'b0;
                xfer_ack = 1'b0;
                ack_cnt  = 0;
            end else if (ack_en) begin
                if (xfer_req != dst_req) begin
                    dst_req = xfer_req;
                    rx_q.push_back(xfer_data);
                    ack_cnt = 3;
                end else if (ack_cnt > 0) begin
                    ack_cnt = ack_cnt - 1;
                    if (ack_cnt == 0) xfer_ack = ~xfer_ack;
                end
            end
            if (done) done_cnt = done_cnt + 1;
            if (xfer_req != prev_req) tog_cnt = tog_cnt + 1;
            if (busy && prev_busy && xfer_req == prev_req && xfer_data != prev_data)
                stable_err = stable_err + 1;
            prev_req  = xfer_req;
            prev_busy = busy;
            prev_data = xfer_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a word from a falling edge; returns once accepted (posedge + 1) or budget expires.
    task automatic send(input logic [7:0] w, input int budget, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_counts();
        rx_q.delete();
        done_cnt   = 0;
        tog_cnt    = 0;
        stable_err = 0;
    endtask

    logic ok;
    int   k;
    int   rdy_early;
    logic p;

    initial begin
        reset_l  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        xfer_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",   32'(xfer_req),  32'd0);
        chk("rst_data",  32'(xfer_data), 32'h00);
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        @(negedge clk);
        reset_l = 1'b1;
        @(posedge clk);
        #1;
        clear_counts();
        repeat (20) @(posedge clk);
        #1;
        chk("idle_req",   32'(xfer_req),  32'd0);
        chk("idle_data",  32'(xfer_data), 32'h00);
        chk("idle_busy",  32'(busy),      32'd0);
        chk("idle_ready", 32'(in_ready),  32'd1);
        chk("idle_events", 32'(done_cnt + tog_cnt), 32'd0);

        // Single word: done arrives 6 edges after the accept edge.
        send(8'hA5, 10, ok);
        chk("single_acc",  32'(ok),        32'd1);
        chk("single_req",  32'(xfer_req),  32'd1);
        chk("single_data", 32'(xfer_data), 32'hA5);
        chk("single_busy", 32'(busy),      32'd1);
        k = 0;
        rdy_early = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = i;
                break;
            end
            if (in_ready) rdy_early = rdy_early + 1;
        end
        chk("single_lat",      32'(k),         32'd6);
        chk("single_rdy_low",  32'(rdy_early), 32'd0);
        chk("single_rdy_back", 32'(in_ready),  32'd1);
        chk("single_data_end", 32'(xfer_data), 32'hA5);
        @(posedge clk);
        #1;
        chk("single_done_1cyc", 32'(done), 32'd0);
        chk("single_busy_end",  32'(busy), 32'd0);
        #1;
        chk("single_done_cnt", 32'(done_cnt), 32'd1);
        chk("single_rx", 32'(rx_q.size() == 1 && rx_q[0] == 8'hA5), 32'd1);

        // Stream 0x01..0x10 with random gaps.
        clear_counts();
        for (int w = 1; w <= 16; w++) begin
            send(8'(w), 200, ok);
            if (!ok) chk("stream_acc_timeout", 32'd0, 32'd1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_done(16, 500, ok);
        chk("stream_wait", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        chk("stream_rx_n",  32'(rx_q.size()), 32'd16);
        chk("stream_done",  32'(done_cnt),    32'd16);
        chk("stream_togs",  32'(tog_cnt),     32'd16);
        chk("stream_stable", 32'(stable_err), 32'd0);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk($sformatf("stream_word%0d", i), 32'(rx_q[i]), 32'(i + 1));

`ifdef CDC_TX_SKID_EN
        // Queued word launches on the completion edge of the first.
        clear_counts();
        p = xfer_req;
        send(8'h11, 10, ok);
        chk("skid_acc1", 32'(ok), 32'd1);
        send(8'h22, 10, ok);
        chk("skid_acc2", 32'(ok), 32'd1);
        chk("skid_hold", 32'(xfer_data), 32'h11);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = 1;
                break;
            end
        end
        chk("skid_done1_seen", 32'(k),         32'd1);
        chk("skid_launch_req", 32'(xfer_req),  32'(p));
        chk("skid_launch_dat", 32'(xfer_data), 32'h22);
        chk("skid_busy",       32'(busy),      32'd1);
        wait_done(2, 50, ok);
        chk("skid_wait2", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        chk("skid_done_cnt", 32'(done_cnt), 32'd2);
        chk("skid_rx", 32'(rx_q.size() == 2 && rx_q[0] == 8'h11 && rx_q[1] == 8'h22), 32'd1);
`endif

        // Ack never returns.
        clear_counts();
        ack_en = 1'b0;
        send(8'h77, 10, ok);
        chk("stall_acc", 32'(ok), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        chk("stall_busy", 32'(busy),      32'd1);
        chk("stall_data", 32'(xfer_data), 32'h77);
`ifdef CDC_TX_SKID_EN
        send(8'h88, 10, ok);
        chk("stall_skid_acc", 32'(ok), 32'd1);
        send(8'h99, 20, ok);
        chk("stall_skid_full", 32'(ok), 32'd0);
`else
        send(8'h88, 20, ok);
        chk("stall_no_acc", 32'(ok), 32'd0);
`endif
        chk("stall_ready", 32'(in_ready),  32'd0);
        chk("stall_data2", 32'(xfer_data), 32'h77);
        #2;
        chk("stall_no_done", 32'(done_cnt), 32'd0);

        // Reset mid-transfer, then recover with 0x3C.
        @(negedge clk);
        reset_l = 1'b0;
        #1;
        chk("mid_rst_req",   32'(xfer_req),  32'd0);
        chk("mid_rst_data",  32'(xfer_data), 32'h00);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_done",  32'(done),      32'd0);
        repeat (2) @(negedge clk);
        ack_en  = 1'b1;
        reset_l = 1'b1;
        @(posedge clk);
        #1;
        clear_counts();
        repeat (5) @(posedge clk);
        #2;
        chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
        send(8'h3C, 10, ok);
        chk("recov_acc", 32'(ok), 32'd1);
        wait_done(1, 30, ok);
        chk("recov_wait", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        chk("recov_done_cnt", 32'(done_cnt), 32'd1);
        chk("recov_rx", 32'(rx_q.size() == 1 && rx_q[0] == 8'h3C), 32'd1);
        chk("recov_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_tx.md
# cdc_tx

Source-domain half of a toggle-handshake multi-bit clock-domain crossing. Accepts words from a local valid/ready producer, holds each word stable on `xfer_data`, signals it by toggling `xfer_req`, then waits for the destination's `xfer_ack` toggle. The ack returns through an internal NSTAGES-deep synchronizer before it is compared. The block sits in the producer clock domain; its partner receiver sits in the consumer domain and samples `xfer_data` only after synchronizing `xfer_req`.

## Interface
- DATAWIDTH, 8, width of transferred word
- NSTAGES, 2, flops in the `xfer_ack` synchronizer (>=2)
- reset_l  input  1  reset, asynchronous, active-low
- clk  input  1  clock, source domain
- in_data  input  DATAWIDTH  word from producer
- in_valid  input  1  `in_data` valid
- in_ready  output  1  block can accept; transfer occurs when `in_valid & in_ready` at a rising edge
- xfer_data  output  DATAWIDTH  registered word to destination; stable while a transfer is outstanding
- xfer_req  output  1  registered request toggle; one toggle per word
- xfer_ack  input  1  ack toggle from destination, asynchronous to `clk`
- done  output  1  one-cycle pulse when a word's ack has been received
- busy  output  1  transfer outstanding (state WAIT)

## Operation
- Reset values: `xfer_data`=0, `xfer_req`=0, `done`=0, `busy`=0, all ack sync stages=0, state IDLE. `in_ready`=1 after reset. The skid buffer, when present, resets empty.
- `ack_s` is the last stage of the `xfer_ack` synchronizer. No other logic samples `xfer_ack` directly.
- State IDLE:
  - `in_ready`=1.
  - On accept: `xfer_data`<=`in_data`, `xfer_req`<=~`xfer_req`, next state WAIT.
- State WAIT:
  - Outstanding when `ack_s` != `xfer_req`.
  - When `ack_s` == `xfer_req`: the word is complete. Next edge: `done`<=1 for one cycle and state returns to IDLE, unless a queued word is launched (see Configuration).
- `xfer_data` never changes while in WAIT except at the edge that completes the current word and launches the next one.
- `ack_s` is ignored in IDLE.
- `busy` = (state == WAIT). It is registered.
- Reset mid-transfer aborts the word with no `done` pulse. The source and destination halves must share a reset event so that the req/ack parity matches afterwards.

## Timing
- Accept at edge N: `xfer_req` toggles and `xfer_data` updates at edge N. `busy` is high from N.
- Ack toggle arriving before edge M appears on `ack_s` after NSTAGES edges. Completion is seen in the cycle after that edge.
- The `done` pulse and the return of `in_ready` (without the skid buffer) occur together, one edge after `ack_s` matches.
- Minimum spacing between accepts without the skid buffer: 1 + (destination round trip) + NSTAGES + 1 cycles.
- `in_ready` is combinational from state and skid occupancy only. It never depends on `in_valid`.

## Configuration
- Macro `CDC_TX_SKID_EN`.
- Defined: adds a one-entry skid buffer.
  - `in_ready` = !skid_full, so one word is accepted during WAIT.
  - At the completion edge with the skid full: `done` pulses, the skid word moves to `xfer_data`, `xfer_req` toggles again, state stays WAIT, skid empties.
  - Completion with the skid empty and a simultaneous accept: the incoming word launches directly at that edge (no skid write).
  - Accept in IDLE always launches directly.
- Undefined: no skid storage. `in_ready` = (state == IDLE).

## Test plan
- Reset then idle: hold `reset_l`=0 → `xfer_req`=0, `xfer_data`=0, `in_ready`=1, `busy`=0. With no `in_valid`, outputs are unchanged for 20 cycles.
- Single word, loopback model (destination acks 3 cycles after seeing req), DATAWIDTH=8, NSTAGES=2:
  - Send 0xA5.
  - `xfer_req` goes 0→1 at the accept edge, `xfer_data`=0xA5 stable until `done`.
  - One `done` pulse. `in_ready` low until `done`.
- Back-to-back stream of 0x01..0x10 with random `in_valid` gaps → the receiver model captures exactly 16 words in order, with 16 `done` pulses and 16 `xfer_req` toggles.
- Ack never returns → `busy` stays 1 and `xfer_data` is held. Without the macro, `in_ready` stays 0. With `CDC_TX_SKID_EN`, exactly one more word is accepted, then `in_ready`=0.
- Reset mid-transfer (assert `reset_l` during WAIT, reset the model too) → all outputs return to reset values with no `done` pulse. The next word 0x3C then transfers correctly.
- With `CDC_TX_SKID_EN`: accept 0x11, then 0x22 during WAIT → 0x22 launches at the completion edge of 0x11 (`xfer_req` toggles the same edge `done` is registered). Two `done` pulses total.
